// File: rtl/spi_slave_ctrl_if.sv
// Bus bundle between the SPI slave controller and its master/RAM side.
// The slave modport is the controller's view; master is the driving side.
interface spi_slave_ctrl_if;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       rd_err;

  modport slave (
    input  ss_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_valid, rd_err
  );

  modport master (
    output ss_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_valid, rd_err
  );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave controller: 10-bit command frames in, 8-bit read data out on miso.
// Optional SPI_CTRL_RD_ADDR_LOCK_EN: rd-data (11) is only served after an rd-addr (10).
module spi_slave_ctrl #(
  parameter int unsigned RD_WAIT_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  spi_slave_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SHIFT_IN, WAIT_TX, SHIFT_OUT, DONE} state_e;

  state_e     state_q, state_d;
  logic [9:0] shift_q, shift_d;
  logic [9:0] rx_data_q, rx_data_d;
  logic [7:0] out_q, out_d;
  logic [3:0] cnt_q, cnt_d;
  logic       miso_q, miso_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rd_err_q, rd_err_d;
  logic       rx_pend_q, rx_pend_d;
  logic       rej_pend_q, rej_pend_d;

  logic [9:0] frame;
  logic       last_bit;
  logic       wait_expired;
  logic       is_rd_data;
  logic       rd_ok;

  // frame is the shift register as it will look once the current mosi bit lands
  assign frame        = {shift_q[8:0], bus.mosi};
  assign last_bit     = (cnt_q == 4'd9);
  assign wait_expired = (cnt_q == 4'(RD_WAIT_MAX - 1));
  assign is_rd_data   = (frame[9:8] == 2'b11);

`ifdef SPI_CTRL_RD_ADDR_LOCK_EN
  logic addr_seen_q, addr_seen_d;

  assign rd_ok = addr_seen_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr_seen_q <= 1'b0;
    else      addr_seen_q <= addr_seen_d;
  end

  always_comb begin
    addr_seen_d = addr_seen_q;
    if (!bus.ss_n && state_q == SHIFT_IN && last_bit) begin
      if (frame[9:8] == 2'b10) addr_seen_d = 1'b1;
      else if (is_rd_data)     addr_seen_d = 1'b0;
    end
  end
`else
  assign rd_ok = 1'b1;
`endif

  // NOTE: every flop, shift register included, is cleared by the async reset so
  // a frame interrupted by reset leaves nothing behind that could strobe later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      rx_data_q  <= '0;
      out_q      <= '0;
      cnt_q      <= '0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rx_pend_q  <= 1'b0;
      rej_pend_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q    <= state_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      rd_err_q   <= rd_err_d;
      rx_pend_q  <= rx_pend_d;
      rej_pend_q <= rej_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.ss_n) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:      state_d = SHIFT_IN;
        SHIFT_IN:  if (last_bit) state_d = (is_rd_data && rd_ok) ? WAIT_TX : DONE;
        WAIT_TX:   if (bus.tx_valid) state_d = SHIFT_OUT;
                   else if (wait_expired) state_d = DONE;
        SHIFT_OUT: if (cnt_q == 4'd7) state_d = DONE;
        DONE:      state_d = DONE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    shift_d    = shift_q;
    out_d      = out_q;
    cnt_d      = cnt_q;
    miso_d     = 1'b0;
    rx_pend_d  = 1'b0;
    rej_pend_d = 1'b0;
    // A strobe scheduled by the last edge is issued even if ss_n has just risen.
    rx_valid_d = rx_pend_q;
    rx_data_d  = rx_pend_q ? shift_q : rx_data_q;
    rd_err_d   = rej_pend_q;

    if (bus.ss_n) begin
      cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          shift_d = frame;
          cnt_d   = 4'd1;
        end
        SHIFT_IN: begin
          shift_d = frame;
          if (last_bit) begin
            cnt_d = '0;
            if (is_rd_data && !rd_ok) rej_pend_d = 1'b1;
            else                      rx_pend_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        WAIT_TX: begin
          if (bus.tx_valid) begin
            miso_d = bus.tx_data[7];
            out_d  = {bus.tx_data[6:0], 1'b0};
            cnt_d  = '0;
          end else if (wait_expired) begin
            rd_err_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        SHIFT_OUT: begin
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
          end else begin
            miso_d = out_q[7];
            out_d  = {out_q[6:0], 1'b0};
            cnt_d  = cnt_q + 4'd1;
          end
        end
        DONE:    cnt_d = cnt_q;
        default: cnt_d = '0;
      endcase
    end
  end

  assign bus.miso     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rd_err   = rd_err_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl: random frames compared cycle by cycle
// against a transaction-level model of when strobes, miso bits and rd_err appear.
module tb_spi_slave_ctrl;
  localparam int RD_WAIT_MAX = 4;
`ifdef SPI_CTRL_RD_ADDR_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  typedef logic [12:0] obs_t;  // {rx_valid, rx_data[9:0], miso, rd_err}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_ctrl_if bus();

  spi_slave_ctrl #(.RD_WAIT_MAX(RD_WAIT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  obs_t       obs_v [32];
  obs_t       exp_v [32];
  int         n_pass  = 0;
  int         n_total = 0;
  logic [9:0] last_rx = '0;
  bit         model_seen = 1'b0;

  function automatic string fmt(obs_t v);
    return $sformatf("rx_valid=%b rx_data=%h miso=%b rd_err=%b", v[12], v[11:2], v[1], v[0]);
  endfunction

  // One clock: drive at the falling edge, observe at the next falling edge.
  task automatic step(input logic ss, input logic m, input logic tv,
                      input logic [7:0] td, output obs_t o);
    bus.ss_n     = ss;
    bus.mosi     = m;
    bus.tx_valid = tv;
    bus.tx_data  = td;
    @(posedge clk);
    @(negedge clk);
    o = {bus.rx_valid, bus.rx_data, bus.miso, bus.rd_err};
  endtask

  // Step 0 carries frame bit 9; ss_n is low for steps 0..ss_low_len-1.
  task automatic run_txn(input logic [9:0] frame, input int ss_low_len, input int total,
                         input int tx_at, input logic [7:0] txd, input bit noise);
    for (int i = 0; i < total; i++) begin
      logic m, tv;
      logic [7:0] td;
      m  = (i < 10) ? frame[4'(9 - i)] : 1'($urandom);
      tv = (i == tx_at) || (noise && i < 10 && $urandom_range(0, 1) == 1);
      td = (i == tx_at) ? txd : 8'($urandom);
      step(i >= ss_low_len, m, tv, td, obs_v[i]);
    end
  endtask

  // Transaction-level expectations: strobe 10 cycles after the first bit, read
  // data on the 8 cycles starting at the accepted tx_valid, timeout RD_WAIT_MAX
  // cycles after the frame completes, rejection error where the strobe would be.
  task automatic model_txn(input logic [9:0] frame, input int ss_low_len, input int total,
                           input int tx_at, input logic [7:0] txd);
    int tx_hi;
    tx_hi = 9 + RD_WAIT_MAX;
    for (int i = 0; i < total; i++) exp_v[i] = {1'b0, last_rx, 2'b00};
    if (ss_low_len >= 10) begin
      if (frame[9:8] == 2'b11 && LOCK && !model_seen) begin
        exp_v[10][0] = 1'b1;
      end else begin
        exp_v[10][12] = 1'b1;
        for (int i = 10; i < total; i++) exp_v[i][11:2] = frame;
        last_rx = frame;
        if (frame[9:8] == 2'b11) begin
          if (tx_at >= 10 && tx_at <= tx_hi)
            for (int j = 0; j < 8; j++) exp_v[tx_at + j][1] = txd[3'(7 - j)];
          else
            exp_v[tx_hi][0] = 1'b1;
        end
      end
      if (frame[9:8] == 2'b10)      model_seen = 1'b1;
      else if (frame[9:8] == 2'b11) model_seen = 1'b0;
    end
  endtask

  task automatic do_txn(input logic [9:0] frame, input int ss_low_len, input int tx_at,
                        input logic [7:0] txd, input bit noise, output int len);
    len = (ss_low_len + 1 > 11) ? ss_low_len + 1 : 11;
    run_txn(frame, ss_low_len, len, tx_at, txd, noise);
    model_txn(frame, ss_low_len, len, tx_at, txd);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ss_n = 1'b1; bus.mosi = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
    #2 rst = 1'b0;
    #1;
    n_total++; if (bus.miso !== 1'b0)     $display("FAIL reset_miso: got %b want 0", bus.miso); else n_pass++;
    n_total++; if (bus.rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); else n_pass++;
    n_total++; if (bus.rx_data !== 10'h0) $display("FAIL reset_rx_data: got %h want 000", bus.rx_data); else n_pass++;
    n_total++; if (bus.rd_err !== 1'b0)   $display("FAIL reset_rd_err: got %b want 0", bus.rd_err); else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    last_rx = '0;
    model_seen = 1'b0;
  endtask

  task automatic test_lock();
    logic [9:0] frames [3];
    int len, tx_at;
    frames[0] = {2'b11, 8'($urandom)};
    frames[1] = {2'b10, 8'($urandom)};
    frames[2] = {2'b11, 8'($urandom)};
    for (int k = 0; k < 3; k++) begin
      logic [7:0] txd;
      txd   = 8'($urandom);
      tx_at = (frames[k][9:8] == 2'b11) ? 11 : -1;
      do_txn(frames[k], (tx_at > 0) ? tx_at + 8 : 10, tx_at, txd, 1'b0, len);
      for (int i = 0; i < len; i++) begin
        n_total++;
        if (obs_v[i] !== exp_v[i]) $display("FAIL lock txn%0d cyc%0d: got %s want %s", k, i, fmt(obs_v[i]), fmt(exp_v[i]));
        else n_pass++;
      end
    end
  endtask

  task automatic test_write();
    int len;
    for (int k = 0; k < 4; k++) begin
      logic [9:0] frame;
      frame = (k == 0) ? 10'h0A5 : {1'b0, 1'($urandom), 8'($urandom)};
      // tx_valid during DONE must be ignored
      do_txn(frame, 10 + k, 10, 8'($urandom), 1'b1, len);
      for (int i = 0; i < len; i++) begin
        n_total++;
        if (obs_v[i] !== exp_v[i]) $display("FAIL write txn%0d cyc%0d: got %s want %s", k, i, fmt(obs_v[i]), fmt(exp_v[i]));
        else n_pass++;
      end
    end
  endtask

  task automatic test_read();
    int len;
    for (int k = 0; k < 6; k++) begin
      logic [9:0] frame;
      logic [7:0] txd;
      int tx_at;
      if (k % 2 == 0) begin
        frame = (k == 0) ? 10'h203 : {2'b10, 8'($urandom)};
        tx_at = -1;
      end else begin
        frame = {2'b11, 8'($urandom)};
        tx_at = (k == 1) ? 12 : $urandom_range(10, 9 + RD_WAIT_MAX);
      end
      txd = (k == 1) ? 8'hC3 : 8'($urandom);
      do_txn(frame, (tx_at > 0) ? tx_at + 8 : 10, tx_at, txd, 1'b1, len);
      for (int i = 0; i < len; i++) begin
        n_total++;
        if (obs_v[i] !== exp_v[i]) $display("FAIL read txn%0d cyc%0d: got %s want %s", k, i, fmt(obs_v[i]), fmt(exp_v[i]));
        else n_pass++;
      end
    end
  endtask

  task automatic test_timeout();
    int len;
    for (int k = 0; k < 2; k++) begin
      logic [9:0] frame;
      frame = (k == 0) ? {2'b10, 8'($urandom)} : {2'b11, 8'($urandom)};
      // the late tx_valid lands one cycle after the wait window closes
      do_txn(frame, (k == 0) ? 10 : 14 + RD_WAIT_MAX, (k == 0) ? -1 : 10 + RD_WAIT_MAX,
             8'hFF, 1'b0, len);
      for (int i = 0; i < len; i++) begin
        n_total++;
        if (obs_v[i] !== exp_v[i]) $display("FAIL timeout txn%0d cyc%0d: got %s want %s", k, i, fmt(obs_v[i]), fmt(exp_v[i]));
        else n_pass++;
      end
    end
  endtask

  task automatic test_abort();
    int len;
    for (int k = 0; k < 2; k++) begin
      do_txn((k == 0) ? 10'($urandom) : 10'h1F0, (k == 0) ? 6 : 10, -1, 8'h00, 1'b0, len);
      for (int i = 0; i < len; i++) begin
        n_total++;
        if (obs_v[i] !== exp_v[i]) $display("FAIL abort txn%0d cyc%0d: got %s want %s", k, i, fmt(obs_v[i]), fmt(exp_v[i]));
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int len;
    logic [7:0] txd;
    obs_t o;
    txd = 8'($urandom);
    do_txn({2'b10, 8'($urandom)}, 10, -1, 8'h00, 1'b0, len);
    for (int i = 0; i < len; i++) begin
      n_total++;
      if (obs_v[i] !== exp_v[i]) $display("FAIL rstmid_addr cyc%0d: got %s want %s", i, fmt(obs_v[i]), fmt(exp_v[i]));
      else n_pass++;
    end
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        // read frame, tx_valid right away, stop after the 4th miso bit is out
        run_txn({2'b11, 8'($urandom)}, 30, 14, 10, txd, 1'b0);
        n_total++;
        if (obs_v[13][1] !== txd[4]) $display("FAIL rstmid_bit3: got miso=%b want %b", obs_v[13][1], txd[4]);
        else n_pass++;
      end else begin
        // all ten bits of a write captured, strobe due on the next edge
        run_txn({2'b01, 8'($urandom)}, 30, 10, -1, 8'h00, 1'b0);
      end
      #1 rst = 1'b0;
      #1;
      o = {bus.rx_valid, bus.rx_data, bus.miso, bus.rd_err};
      n_total++;
      if (o !== 13'h0) $display("FAIL rstmid_async%0d: got %s want all zero", k, fmt(o));
      else n_pass++;
      bus.ss_n = 1'b1;
      bus.tx_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      last_rx = '0;
      model_seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        step(1'b1, 1'($urandom), 1'b0, 8'h00, o);
        n_total++;
        if (o !== 13'h0) $display("FAIL rstmid_after%0d cyc%0d: got %s want all zero", k, i, fmt(o));
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int len;
    for (int k = 0; k < 14; k++) begin
      logic [9:0] frame;
      int ss_len, tx_at;
      frame = 10'($urandom);
      tx_at = 10;
      if (k % 5 == 4) begin
        ss_len = $urandom_range(2, 9);
      end else if (frame[9:8] == 2'b11) begin
        if ($urandom_range(0, 2) != 0) begin
          tx_at  = $urandom_range(10, 9 + RD_WAIT_MAX);
          ss_len = tx_at + 8 + $urandom_range(0, 2);
        end else begin
          tx_at  = -1;
          ss_len = 10 + RD_WAIT_MAX + $urandom_range(0, 2);
        end
      end else begin
        ss_len = 10 + $urandom_range(0, 3);
      end
      do_txn(frame, ss_len, tx_at, 8'($urandom), 1'b1, len);
      for (int i = 0; i < len; i++) begin
        n_total++;
        if (obs_v[i] !== exp_v[i]) $display("FAIL b2b txn%0d cyc%0d: got %s want %s", k, i, fmt(obs_v[i]), fmt(exp_v[i]));
        else n_pass++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, time=%0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lock();
    test_write();
    test_read();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001 Parameter: RD_WAIT_MAX, default 4, is the maximum number of cycles spent in WAIT_TX before a read aborts (legal range 1..15).
REQ-002 Port: clk, input, 1, rising-edge clock.
REQ-003 Port: rst, input, 1, reset, asynchronous, active-low.
REQ-004 Port: ss_n, input, 1, SPI slave select, active-low, synchronous to clk.
REQ-005 Port: mosi, input, 1, serial data in, MSB first, sampled on clk rising edge.
REQ-006 Port: miso, output, 1, serial data out, MSB first, registered.
REQ-007 Port: rx_data, output, 10, frame to RAM; [9:8] is the command (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data) and [7:0] is the payload.
REQ-008 Port: rx_valid, output, 1, one-cycle strobe qualifying rx_data.
REQ-009 Port: tx_data, input, 8, read data from RAM.
REQ-010 Port: tx_valid, input, 1, one-cycle strobe qualifying tx_data.
REQ-011 Port: rd_err, output, 1, one-cycle pulse on read timeout or rejected read.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, SHIFT_IN, WAIT_TX, SHIFT_OUT, DONE.
REQ-013 From IDLE, on ss_n=0 the FSM SHALL enter SHIFT_IN and capture mosi on that same edge as bit 9.
REQ-014 SHIFT_IN SHALL capture one bit per cycle into a 10-bit shift register, MSB first, using a 4-bit counter.
REQ-015 On capture of bit 0 (10th bit), the block SHALL load rx_data and assert rx_valid on the next cycle for exactly 1 cycle, giving 10 cycles from the first bit to the strobe.
REQ-016 After the 10th bit, commands 00, 01 and 10 SHALL go to DONE, and command 11 SHALL go to WAIT_TX.
REQ-017 In WAIT_TX, tx_valid=1 SHALL latch tx_data into the output shift register and move the FSM to SHIFT_OUT.
REQ-018 In WAIT_TX, if tx_valid does not arrive within RD_WAIT_MAX cycles, the block SHALL pulse rd_err for 1 cycle, go to DONE, and hold miso at 0.
REQ-019 In SHIFT_OUT, miso SHALL present tx_data[7] on the first SHIFT_OUT cycle, then bits 6..0 on successive cycles (8 cycles total), then go to DONE.
REQ-020 In DONE, the FSM SHALL stay until ss_n=1, then return to IDLE; extra mosi bits in DONE SHALL be ignored.
REQ-021 ss_n=1 in any state SHALL force IDLE on the next edge, clear the bit counter, drive miso=0, and suppress any pending rx_valid that was not yet issued.
REQ-022 An rx_valid already scheduled on the same edge that ss_n rises SHALL still be issued (the frame was complete).
REQ-023 tx_valid outside WAIT_TX SHALL be ignored.
REQ-024 miso SHALL be 0 whenever the FSM is not in SHIFT_OUT.
REQ-025 rx_data SHALL hold its last value between strobes.

Reset
REQ-026 On rst=0, the FSM SHALL go to IDLE asynchronously.
REQ-027 On rst=0, the outputs SHALL reset to miso=0, rx_valid=0, rx_data=0, rd_err=0, with all counters and shift registers 0 and the address-seen flag 0.
REQ-028 When rst is asserted mid-frame, the frame SHALL be discarded with no strobe after release.

Configuration
REQ-029 With SPI_CTRL_RD_ADDR_LOCK_EN defined, a command-11 frame SHALL proceed to WAIT_TX only if a command-10 frame completed since reset or since the last command-11.
REQ-030 With SPI_CTRL_RD_ADDR_LOCK_EN defined, a command-11 frame without a prior command-10 SHALL still have its rx_valid suppressed, SHALL pulse rd_err, and SHALL go to DONE.
REQ-031 With SPI_CTRL_RD_ADDR_LOCK_EN undefined, command 11 SHALL always issue rx_valid and enter WAIT_TX, and no address-seen flag SHALL exist.

Verification
REQ-032 Write-address scenario: ss_n low, mosi 00_1010_0101 -> rx_data=0x0A5 with rx_valid high for 1 cycle, 10 cycles after the first bit; miso stays 0.
REQ-033 Read scenario: frame 10_0000_0011, then frame 11_xxxx_xxxx with tx_valid and tx_data=0xC3 two cycles later -> miso=1,1,0,0,0,0,1,1 on 8 consecutive cycles.
REQ-034 Timeout scenario: frame 11 with no tx_valid -> rd_err pulses RD_WAIT_MAX=4 cycles after entering WAIT_TX, and miso stays 0.
REQ-035 Abort scenario: ss_n rises after 6 bits -> no rx_valid; the next full frame 01_1111_0000 strobes 0x1F0.
REQ-036 Reset scenario: rst low during SHIFT_OUT bit 3 -> miso=0 immediately and state IDLE; no strobe after release.
REQ-037 Configuration scenario: with SPI_CTRL_RD_ADDR_LOCK_EN defined, command 11 issued first after reset -> rd_err pulses and there is no rx_valid; after a command-10 frame, command 11 succeeds.
